// File: rtl/dmem_responder.sv
// Data-memory responder: combinational lane-aligned reads, synchronous byte-enabled writes,
// sticky illegal-access capture and legal read/write counters.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_memRead,
  input  logic        dmem_memWrite,
  input  logic [1:0]  dmem_maskMode,
  input  logic        dmem_sext,
  input  logic [31:0] dmem_writeData,
  output logic [31:0] dmem_readData,
  input  logic        err_clr,
  output logic        err,
  output logic [31:0] err_addr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] MASK_BYTE = 2'd0;
  localparam logic [1:0] MASK_HALF = 2'd1;
  localparam logic [1:0] MASK_WORD = 2'd2;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        err_q,      err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] rd_cnt_q,   rd_cnt_d;
  logic [31:0] wr_cnt_q,   wr_cnt_d;

  logic [AW-1:0] idx_s;
  logic [1:0]    lane_s;
  logic          access_s;
  logic          illegal_s;
  logic          rd_en_s;
  logic          wr_en_s;
  logic [31:0]   old_word_s;
  logic [31:0]   shifted_s;
  logic [31:0]   wr_rep_s;
  logic [3:0]    be_s;
  logic [31:0]   new_word_s;
  logic [31:0]   rdata_s;

  assign idx_s      = dmem_addr[AW+1:2];
  assign lane_s     = dmem_addr[1:0];
  assign old_word_s = mem_q[idx_s];
  assign shifted_s  = old_word_s >> {lane_s, 3'b000};

  // Request decode: legality, enables, byte lanes and replicated store data.
  always_comb begin
    access_s  = dmem_valid & (dmem_memRead | dmem_memWrite);
    illegal_s = 1'b0;
    be_s      = 4'b0000;
    wr_rep_s  = 32'h0000_0000;
    case (dmem_maskMode)
      MASK_BYTE: begin
        be_s     = 4'b0001 << lane_s;
        wr_rep_s = {4{dmem_writeData[7:0]}};
      end
      MASK_HALF: begin
        illegal_s = dmem_addr[0];
        be_s      = dmem_addr[1] ? 4'b1100 : 4'b0011;
        wr_rep_s  = {2{dmem_writeData[15:0]}};
      end
      MASK_WORD: begin
        illegal_s = (lane_s != 2'b00);
        be_s      = 4'b1111;
        wr_rep_s  = dmem_writeData;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
    if (dmem_addr[31:AW+2] != '0) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = illegal_s;
    end
    illegal_s = illegal_s & access_s;
    rd_en_s   = dmem_valid & dmem_memRead  & ~illegal_s;
    wr_en_s   = dmem_valid & dmem_memWrite & ~illegal_s;
  end

  // Merge the addressed lanes of the store into the current word.
  always_comb begin
    new_word_s = old_word_s;
    for (int i = 0; i < 4; i++) begin
      if (be_s[i]) begin
        new_word_s[8*i +: 8] = wr_rep_s[8*i +: 8];
      end else begin
        new_word_s[8*i +: 8] = old_word_s[8*i +: 8];
      end
    end
  end

  // Read data extraction and extension; zero when no legal read is presented.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (rd_en_s) begin
      case (dmem_maskMode)
        MASK_BYTE: rdata_s = {{24{dmem_sext & shifted_s[7]}}, shifted_s[7:0]};
        MASK_HALF: rdata_s = {{16{dmem_sext & shifted_s[15]}}, shifted_s[15:0]};
        MASK_WORD: rdata_s = old_word_s;
        default:   rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign dmem_readData = rdata_s;

  // Error capture and counter next-state; a new illegal access wins over a clear.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    rd_cnt_d   = rd_cnt_q + {31'd0, rd_en_s};
    wr_cnt_d   = wr_cnt_q + {31'd0, wr_en_s};
    if (illegal_s) begin
      err_d      = 1'b1;
      err_addr_d = (err_q & ~err_clr) ? err_addr_q : dmem_addr;
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_addr_d = 32'h0000_0000;
    end else begin
      err_d      = err_q;
      err_addr_d = err_addr_q;
    end
  end

  // Status and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= 32'h0000_0000;
      rd_cnt_q   <= 32'h0000_0000;
      wr_cnt_q   <= 32'h0000_0000;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Storage array is never cleared; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_q[idx_s] <= new_word_s;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign rd_cnt   = rd_cnt_q;
  assign wr_cnt   = wr_cnt_q;

endmodule
